// File: rtl/rat_ckpt.sv
// rat_ckpt: register alias table for the rename stage.
// Translates RENAME_WIDTH instructions per cycle with intra-group bypass,
// reports displaced mappings, and keeps a circular buffer of map snapshots
// that can be restored in a single cycle on a branch mispredict.
module rat_ckpt #(
  parameter int NUM_AREGS    = 32,
  parameter int NUM_PREGS    = 64,
  parameter int RENAME_WIDTH = 2,
  parameter int NUM_CKPTS    = 4,
  localparam int AW = $clog2(NUM_AREGS),
  localparam int PW = $clog2(NUM_PREGS),
  localparam int CW = $clog2(NUM_CKPTS),
  localparam int SW = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [RENAME_WIDTH-1:0][1:0][AW-1:0] src_areg,
  output logic [RENAME_WIDTH-1:0][1:0][PW-1:0] src_preg,
  input  logic [RENAME_WIDTH-1:0]              wr_en,
  input  logic [RENAME_WIDTH-1:0][AW-1:0]      wr_areg,
  input  logic [RENAME_WIDTH-1:0][PW-1:0]      wr_preg,
  output logic [RENAME_WIDTH-1:0][PW-1:0]      old_preg,
  input  logic                                 ckpt_req,
  input  logic [SW-1:0]                        ckpt_slot,
  output logic                                 ckpt_ack,
  output logic [CW-1:0]                        ckpt_id,
  output logic                                 ckpt_full,
  input  logic                                 release_valid,
  input  logic                                 restore_valid,
  input  logic [CW-1:0]                        restore_id
);

  logic [PW-1:0] map_q    [NUM_AREGS];
  logic [PW-1:0] ckpt_q   [NUM_CKPTS][NUM_AREGS];
  logic [PW-1:0] map_next [NUM_AREGS];
  logic [PW-1:0] snap_map [NUM_AREGS];
  logic [CW:0]   head_q;
  logic [CW:0]   tail_q;
  logic [CW:0]   count;
  logic [CW:0]   restore_ptr;
  logic          release_ok;

  // Occupancy is the pointer distance; the wrap bit separates full from empty.
  assign count      = tail_q - head_q;
  assign ckpt_full  = (count == (CW+1)'(NUM_CKPTS));
  assign ckpt_ack   = ckpt_req && !ckpt_full && !restore_valid;
  assign ckpt_id    = tail_q[CW-1:0];
  assign release_ok = release_valid && (count != '0);

  // Source and displaced-mapping lookup; an older slot in the same group
  // writing the same areg overrides the stored map, the youngest such slot wins.
  always_comb begin
    for (int s = 0; s < RENAME_WIDTH; s++) begin
      for (int j = 0; j < 2; j++) begin
        src_preg[s][j] = map_q[src_areg[s][j]];
        for (int t = 0; t < s; t++) begin
          if (wr_en[t] && (wr_areg[t] == src_areg[s][j])) begin
            src_preg[s][j] = wr_preg[t];
          end
        end
        if (src_areg[s][j] == '0) begin
          src_preg[s][j] = '0;
        end
      end
      old_preg[s] = map_q[wr_areg[s]];
      for (int t = 0; t < s; t++) begin
        if (wr_en[t] && (wr_areg[t] == wr_areg[s])) begin
          old_preg[s] = wr_preg[t];
        end
      end
      if (wr_areg[s] == '0) begin
        old_preg[s] = '0;
      end
    end
  end

  // Next map after all slot writes, and the snapshot view that only includes
  // the writes of slots up to and including ckpt_slot.
  always_comb begin
    for (int i = 0; i < NUM_AREGS; i++) begin
      map_next[i] = map_q[i];
      snap_map[i] = map_q[i];
    end
    for (int s = 0; s < RENAME_WIDTH; s++) begin
      if (wr_en[s] && (wr_areg[s] != '0)) begin
        map_next[wr_areg[s]] = wr_preg[s];
        if (s <= int'(ckpt_slot)) begin
          snap_map[wr_areg[s]] = wr_preg[s];
        end
      end
    end
  end

  // Rebuild the full pointer for restore_id: ids below the head index sit
  // past the wrap point, so they take the inverted head wrap bit.
  always_comb begin
    restore_ptr = {head_q[CW], restore_id};
    if (restore_id < head_q[CW-1:0]) begin
      restore_ptr[CW] = ~head_q[CW];
    end
  end

  // Map and pointer update; a restore discards this cycle's writes and checkpoint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        map_q[i] <= PW'(i);
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (restore_valid) begin
        for (int i = 0; i < NUM_AREGS; i++) begin
          map_q[i] <= ckpt_q[restore_id][i];
        end
        tail_q <= restore_ptr;
      end else begin
        for (int i = 0; i < NUM_AREGS; i++) begin
          map_q[i] <= map_next[i];
        end
        if (ckpt_ack) begin
          tail_q <= tail_q + (CW+1)'(1);
        end
      end
      if (release_ok) begin
        head_q <= head_q + (CW+1)'(1);
      end
    end
  end

  // Snapshot storage; contents are only meaningful while the slot is live.
  always_ff @(posedge clk) begin
    if (ckpt_ack) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        ckpt_q[tail_q[CW-1:0]][i] <= snap_map[i];
      end
    end
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// tb_rat_ckpt: directed and randomized checks of rat_ckpt against a
// behavioural model built from a plain map array and a queue of live ids.
module tb_rat_ckpt;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0][1:0][4:0]  src_areg;
  logic [1:0][1:0][5:0]  src_preg;
  logic [1:0]            wr_en;
  logic [1:0][4:0]       wr_areg;
  logic [1:0][5:0]       wr_preg;
  logic [1:0][5:0]       old_preg;
  logic                  ckpt_req;
  logic [0:0]            ckpt_slot;
  logic                  ckpt_ack;
  logic [1:0]            ckpt_id;
  logic                  ckpt_full;
  logic                  release_valid;
  logic                  restore_valid;
  logic [1:0]            restore_id;

  logic [1:0][1:0][4:0]  nx_sa;
  logic [1:0]            nx_we;
  logic [1:0][4:0]       nx_wa;
  logic [1:0][5:0]       nx_wp;
  logic                  nx_cr;
  logic [0:0]            nx_cs;
  logic                  nx_rel;
  logic                  nx_rv;
  logic [1:0]            nx_rid;

  int m_map [32];
  int ck_map [4][32];
  int live [$];
  int m_tail;

  int obs_src [2][2];
  int obs_old [2];
  int obs_ack;
  int obs_id;
  int obs_full;

  int checks = 0;
  int errors = 0;

  rat_ckpt dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_areg      (src_areg),
    .src_preg      (src_preg),
    .wr_en         (wr_en),
    .wr_areg       (wr_areg),
    .wr_preg       (wr_preg),
    .old_preg      (old_preg),
    .ckpt_req      (ckpt_req),
    .ckpt_slot     (ckpt_slot),
    .ckpt_ack      (ckpt_ack),
    .ckpt_id       (ckpt_id),
    .ckpt_full     (ckpt_full),
    .release_valid (release_valid),
    .restore_valid (restore_valid),
    .restore_id    (restore_id)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) m_map[i] = i;
    live.delete();
    m_tail = 0;
  endtask

  task automatic clearNext();
    nx_sa  = '0;
    nx_we  = '0;
    nx_wa  = '0;
    nx_wp  = '0;
    nx_cr  = 1'b0;
    nx_cs  = 1'b0;
    nx_rel = 1'b0;
    nx_rv  = 1'b0;
    nx_rid = '0;
  endtask

  task automatic driveInputs();
    src_areg      = nx_sa;
    wr_en         = nx_we;
    wr_areg       = nx_wa;
    wr_preg       = nx_wp;
    ckpt_req      = nx_cr;
    ckpt_slot     = nx_cs;
    release_valid = nx_rel;
    restore_valid = nx_rv;
    restore_id    = nx_rid;
  endtask

  // One cycle: drive, check all combinational outputs against the model,
  // then advance the model across the clock edge.
  task automatic applyStimulus();
    int work [32];
    int snap [32];
    int a, e, rid, k;
    bit full, e_ack, rel_ok;
    @(negedge clk);
    driveInputs();
    #1;
    for (int i = 0; i < 32; i++) begin
      work[i] = m_map[i];
      snap[i] = m_map[i];
    end
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 2; j++) begin
        a = int'(nx_sa[s][j]);
        e = (a == 0) ? 0 : work[a];
        obs_src[s][j] = int'(src_preg[s][j]);
        checkOutput($sformatf("src_preg[%0d][%0d] a%0d", s, j, a), obs_src[s][j], e);
      end
      a = int'(nx_wa[s]);
      e = (a == 0) ? 0 : work[a];
      obs_old[s] = int'(old_preg[s]);
      checkOutput($sformatf("old_preg[%0d] a%0d", s, a), obs_old[s], e);
      if (nx_we[s] && a != 0) work[a] = int'(nx_wp[s]);
      if (s == int'(nx_cs)) begin
        for (int i = 0; i < 32; i++) snap[i] = work[i];
      end
    end
    full  = (live.size() == 4);
    e_ack = nx_cr && !full && !nx_rv;
    obs_ack  = int'(ckpt_ack);
    obs_id   = int'(ckpt_id);
    obs_full = int'(ckpt_full);
    checkOutput("ckpt_ack", obs_ack, int'(e_ack));
    checkOutput("ckpt_id", obs_id, m_tail);
    checkOutput("ckpt_full", obs_full, int'(full));
    @(posedge clk);
    rel_ok = nx_rel && (live.size() > 0);
    if (nx_rv) begin
      rid = int'(nx_rid);
      for (int i = 0; i < 32; i++) m_map[i] = ck_map[rid][i];
      k = -1;
      for (int q = 0; q < live.size(); q++) begin
        if (live[q] == rid && k < 0) k = q;
      end
      if (k < 0) k = live.size();
      while (live.size() > k) void'(live.pop_back());
      m_tail = rid;
    end else begin
      for (int i = 0; i < 32; i++) m_map[i] = work[i];
      if (e_ack) begin
        for (int i = 0; i < 32; i++) ck_map[m_tail][i] = snap[i];
        live.push_back(m_tail);
        m_tail = (m_tail + 1) % 4;
      end
    end
    if (rel_ok) void'(live.pop_front());
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    clearNext();
    driveInputs();
    resetModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Reset sanity
    clearNext();
    nx_sa[0][0] = 5'd5;
    nx_sa[0][1] = 5'd0;
    applyStimulus();
    checkOutput("plan_reset_a5", obs_src[0][0], 5);
    checkOutput("plan_reset_a0", obs_src[0][1], 0);
    checkOutput("plan_reset_full", obs_full, 0);
    checkOutput("plan_reset_id", obs_id, 0);

    // Intra-group bypass
    clearNext();
    nx_we = 2'b11;
    nx_wa[0] = 5'd3; nx_wp[0] = 6'd40;
    nx_wa[1] = 5'd3; nx_wp[1] = 6'd41;
    nx_sa[1][0] = 5'd3;
    applyStimulus();
    checkOutput("plan_bypass_src", obs_src[1][0], 40);
    checkOutput("plan_bypass_old0", obs_old[0], 3);
    checkOutput("plan_bypass_old1", obs_old[1], 40);
    clearNext();
    nx_sa[0][0] = 5'd3;
    applyStimulus();
    checkOutput("plan_bypass_next", obs_src[0][0], 41);

    // Checkpoint and restore; slot1 write is excluded from the first snapshot
    clearNext();
    nx_we = 2'b11;
    nx_wa[0] = 5'd7; nx_wp[0] = 6'd50;
    nx_wa[1] = 5'd7; nx_wp[1] = 6'd55;
    nx_cr = 1'b1; nx_cs = 1'b0;
    applyStimulus();
    checkOutput("plan_ckpt0_ack", obs_ack, 1);
    checkOutput("plan_ckpt0_id", obs_id, 0);
    clearNext();
    nx_we = 2'b01; nx_wa[0] = 5'd7; nx_wp[0] = 6'd51;
    nx_cr = 1'b1;
    applyStimulus();
    checkOutput("plan_ckpt1_id", obs_id, 1);
    clearNext();
    nx_we = 2'b01; nx_wa[0] = 5'd7; nx_wp[0] = 6'd52;
    applyStimulus();
    clearNext();
    nx_rv = 1'b1; nx_rid = 2'd0;
    applyStimulus();
    clearNext();
    nx_sa[0][0] = 5'd7;
    nx_cr = 1'b1;
    applyStimulus();
    checkOutput("plan_restore_a7", obs_src[0][0], 50);
    checkOutput("plan_restore_full", obs_full, 0);
    checkOutput("plan_restore_newid", obs_id, 0);

    // Fill, overflow, release and wrap
    for (int n = 0; n < 3; n++) begin
      clearNext();
      nx_cr = 1'b1;
      applyStimulus();
    end
    clearNext();
    nx_cr = 1'b1;
    applyStimulus();
    checkOutput("plan_full_flag", obs_full, 1);
    checkOutput("plan_full_noack", obs_ack, 0);
    clearNext();
    nx_rel = 1'b1;
    applyStimulus();
    clearNext();
    nx_cr = 1'b1;
    applyStimulus();
    checkOutput("plan_wrap_id", obs_id, 0);
    checkOutput("plan_wrap_ack", obs_ack, 1);
    clearNext();
    applyStimulus();
    checkOutput("plan_wrap_full", obs_full, 1);

    // Restore has priority over writes and checkpoint requests
    clearNext();
    nx_we = 2'b11;
    nx_wa[0] = 5'd7; nx_wp[0] = 6'd60;
    nx_wa[1] = 5'd9; nx_wp[1] = 6'd61;
    nx_cr = 1'b1;
    nx_rv = 1'b1; nx_rid = 2'd2;
    applyStimulus();
    checkOutput("plan_prio_noack", obs_ack, 0);
    clearNext();
    nx_sa[0][0] = 5'd7;
    nx_sa[0][1] = 5'd9;
    applyStimulus();
    checkOutput("plan_prio_a7", obs_src[0][0], 50);
    checkOutput("plan_prio_a9", obs_src[0][1], 9);
    checkOutput("plan_prio_id", obs_id, 2);
    checkOutput("plan_prio_full", obs_full, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      clearNext();
      for (int s = 0; s < 2; s++) begin
        for (int j = 0; j < 2; j++) begin
          if ($urandom % 4 == 0) nx_sa[s][j] = 5'($urandom_range(0, 31));
          else nx_sa[s][j] = 5'($urandom_range(0, 7));
        end
        nx_wa[s] = 5'($urandom_range(0, 7));
        nx_wp[s] = 6'($urandom_range(0, 63));
      end
      nx_we  = 2'($urandom);
      nx_cr  = ($urandom % 3 == 0);
      nx_cs  = 1'($urandom);
      nx_rel = ($urandom % 5 == 0);
      if (live.size() > 0 && ($urandom % 8 == 0)) begin
        nx_rv  = 1'b1;
        nx_rid = 2'(live[$urandom_range(0, live.size() - 1)]);
        if (nx_rel && int'(nx_rid) == live[0]) nx_rel = 1'b0;
      end
      applyStimulus();
    end

    // Asynchronous reset in the middle of a restore
    guard = 0;
    while (live.size() > 0 && guard < 8) begin
      clearNext();
      nx_rel = 1'b1;
      applyStimulus();
      guard++;
    end
    clearNext();
    nx_we = 2'b01; nx_wa[0] = 5'd7; nx_wp[0] = 6'd33;
    nx_cr = 1'b1;
    applyStimulus();
    clearNext();
    nx_sa[0][0] = 5'd7;
    nx_sa[0][1] = 5'd3;
    nx_rv = 1'b1;
    nx_rid = 2'((live.size() > 0) ? live[0] : 0);
    @(negedge clk);
    driveInputs();
    #1;
    checkOutput("areset_before_a7", int'(src_preg[0][0]), 33);
    rst_n = 1'b0;
    #1;
    checkOutput("areset_a7", int'(src_preg[0][0]), 7);
    checkOutput("areset_a3", int'(src_preg[0][1]), 3);
    checkOutput("areset_id", int'(ckpt_id), 0);
    checkOutput("areset_full", int'(ckpt_full), 0);
    clearNext();
    driveInputs();
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    clearNext();
    nx_sa[0][0] = 5'd7;
    nx_cr = 1'b1;
    applyStimulus();
    checkOutput("areset_after_a7", obs_src[0][0], 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rat_ckpt.md
# rat_ckpt

Parametrised register alias table for the rename stage with branch checkpointing. It translates RENAME_WIDTH instructions per cycle (two sources and one destination each), with intra-group dependency bypass. It returns the displaced physical register for ROB freeing. It snapshots the map on branches and restores any snapshot in one cycle on mispredict. It sits between Rename, which drives all requests, and the ROB/branch unit, which drives release and restore.

## Interface
Parameters:
- NUM_AREGS, 32, architectural registers; areg 0 is hardwired to preg 0.
- NUM_PREGS, 64, physical registers; must be >= NUM_AREGS.
- RENAME_WIDTH, 2, instructions renamed per cycle.
- NUM_CKPTS, 4, checkpoint slots; power of two.

Ports (AW = clog2(NUM_AREGS), PW = clog2(NUM_PREGS), CW = clog2(NUM_CKPTS)):
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- src_areg  in  [RENAME_WIDTH][2]×AW  source aregs per slot.
- src_preg  out  [RENAME_WIDTH][2]×PW  translated sources; combinational.
- wr_en  in  RENAME_WIDTH  slot s writes a new mapping.
- wr_areg  in  [RENAME_WIDTH]×AW  destination areg per slot.
- wr_preg  in  [RENAME_WIDTH]×PW  newly allocated preg per slot.
- old_preg  out  [RENAME_WIDTH]×PW  mapping displaced by slot s; combinational.
- ckpt_req  in  1  take a checkpoint this cycle.
- ckpt_slot  in  clog2(RENAME_WIDTH)  the checkpoint includes writes of slots 0..ckpt_slot.
- ckpt_ack  out  1  checkpoint accepted; combinational.
- ckpt_id  out  CW  id of the accepted checkpoint (the current tail).
- ckpt_full  out  1  all NUM_CKPTS slots are in use.
- release_valid  in  1  free the oldest checkpoint (its branch resolved correctly).
- restore_valid  in  1  mispredict: restore the map from restore_id.
- restore_id  in  CW  checkpoint to restore; must be live.

## Operation
- State:
  - map[NUM_AREGS]×PW.
  - ckpt[NUM_CKPTS] map copies.
  - head and tail pointers, each CW+1 bits with a wrap bit.
  - count = tail − head.
  - ckpt_full = (count == NUM_CKPTS).
- Reset:
  - map[i] = i.
  - head = tail = 0.
  - Checkpoint contents are don't-care.
  - Outputs reflect the reset map: ckpt_full=0, ckpt_ack=0, ckpt_id=0.
- Source read for slot s, operand j:
  - Start from map[src_areg].
  - Override with wr_preg of the highest slot t<s where wr_en[t] is set and wr_areg[t]==src_areg.
  - If src_areg==0, the result is 0.
- old_preg[s]: same bypass rule applied to wr_areg[s], considering slots t<s only.
- Write:
  - Each slot with wr_en set and wr_areg≠0 updates the map at the clock edge.
  - If several slots write the same areg, the highest slot wins.
  - Writes to areg 0 are ignored, and old_preg for them is 0.
- Checkpoint:
  - ckpt_ack = ckpt_req & !ckpt_full & !restore_valid.
  - On ack: ckpt[tail] ← map with the writes of slots 0..ckpt_slot applied; tail ← tail+1.
  - A request while full is dropped, with no other effect; Rename must stall.
- Release: when release_valid and count>0, head ← head+1. A release while empty is ignored.
- Restore:
  - restore_valid has priority over all wr_en and ckpt_req in the same cycle; those are discarded.
  - map ← ckpt[restore_id].
  - tail ← the pointer for restore_id, matching wrap bit: the restored checkpoint and all younger ones are freed.
- Simultaneous release and restore:
  - Both apply: head+1, tail per restore.
  - restore_id == head together with release is illegal (bench assertion).
- Pointer wrap: indices use the low CW bits, and the wrap bit distinguishes full from empty.

## Timing
- Translation, old_preg, ckpt_ack and ckpt_id are combinational: zero latency in the same cycle.
- Map writes are visible to reads on the cycle after the edge.
- A checkpoint is written on the acknowledging edge.
- ckpt_full updates one cycle after the ack or release.
- Restore takes one cycle: reads in the cycle after restore_valid see the restored map, and ckpt_full/ckpt_id reflect the new tail.
- Reset is asynchronous: asserting rst_n=0 mid-operation immediately forces reset state.
- Deassertion of rst_n is synchronised externally.

## Test plan
- Reset sanity: after reset, src_areg=5 → src_preg=5; src_areg=0 → 0; ckpt_full=0.
- Intra-group bypass: slot0 writes a3→p40 and slot1 reads a3 in the same cycle → slot1 sees p40, old_preg[0]=3. If slot1 also writes a3→p41, the next cycle a3 reads p41 and old_preg[1]=40.
- Checkpoint/restore:
  - Map a7→p50, then checkpoint with ckpt_slot=0 (ckpt_id=0).
  - Map a7→p51, then checkpoint (id 1).
  - Map a7→p52.
  - Restore id 0 → next cycle a7 reads p50 and count=0; a new checkpoint receives id 0.
- Full/wrap:
  - Four checkpoints → ckpt_full=1; a fifth request gives ckpt_ack=0 and the state is unchanged.
  - Release one, then request → ckpt_id=0 (wrapped), ckpt_full=1.
- Priority: restore_valid with wr_en=11 and ckpt_req in the same cycle → writes and checkpoint discarded, ckpt_ack=0, map equals the checkpoint.
- Async reset mid-stream: pull rst_n low during restore → identity map and head=tail=0 immediately.
